// File: rtl/dffr_pipe_scan_if.sv
// Upstream/downstream handshake bundle for the resettable scan pipeline.
interface dffr_pipe_scan_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             DV;
  logic             DR;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             QV;
  logic             QR;

  // Environment side: drives upstream data and downstream ready
  modport master (
    output D, DV, QR,
    input  DR, Q, QN, QV
  );

  // Pipeline side
  modport slave (
    input  D, DV, QR,
    output DR, Q, QN, QV
  );
endinterface

// File: rtl/dffr_pipe_scan.sv
// WIDTH-bit, DEPTH-stage elastic register pipeline with sync active-low reset,
// valid/ready stall handshake, Q/QN outputs and a mux-D scan chain through all data bits.
module dffr_pipe_scan #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               CK,
  input  logic               RN,
  input  logic               SE,
  input  logic               SI,
  output logic               SO,
  dffr_pipe_scan_if.slave    bus
);

  logic [DEPTH-1:0]       v_q;
  logic [DEPTH-1:0]       v_d;
  logic [WIDTH-1:0]       d_q [DEPTH];
  logic [WIDTH-1:0]       d_d [DEPTH];
  logic [DEPTH:0]         r;
  logic [DEPTH-1:0]       vin;
  logic [WIDTH-1:0]       din [DEPTH];
  logic [DEPTH*WIDTH:0]   scan_ext;

  // Ready chain: stage i can load if it, or any stage after it, is empty, or downstream is ready.
  // Built as a running OR from the output end so no bit of r is read back in the same block.
  always_comb begin
    logic acc;
    acc      = bus.QR;
    r        = '0;
    r[DEPTH] = bus.QR;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      acc              = acc | ~v_q[DEPTH-1-k];
      r[DEPTH-1-k]     = acc;
    end
  end

  // Per-stage incoming word: stage 0 from upstream, stage i from stage i-1
  always_comb begin
    vin    = '0;
    vin[0] = bus.DV;
    din[0] = bus.D;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      vin[i] = v_q[i-1];
      din[i] = d_q[i-1];
    end
  end

  // Scan chain as one flat vector with SI appended at the bottom; a shift is a re-slice of it
  always_comb begin
    scan_ext    = '0;
    scan_ext[0] = SI;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_ext[i*WIDTH+1 +: WIDTH] = d_q[i];
    end
  end

  // Next state: scan shift (valids frozen) or elastic advance
  always_comb begin
    v_d = v_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (SE) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_d[i] = scan_ext[i*WIDTH +: WIDTH];
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r[i]) begin
          v_d[i] = vin[i];
          if (vin[i]) begin
            d_d[i] = din[i];
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset overriding scan and handshake
  always_ff @(posedge CK) begin
    if (!RN) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= RESET_VAL;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  // Outputs: handshake is suppressed while scanning
  always_comb begin
    bus.Q  = d_q[DEPTH-1];
    bus.QN = ~d_q[DEPTH-1];
    bus.QV = v_q[DEPTH-1] & ~SE;
    bus.DR = r[0] & ~SE;
    SO     = d_q[DEPTH-1][WIDTH-1];
  end

endmodule

// File: tb/tb_dffr_pipe_scan.sv
// Directed self-checking bench for dffr_pipe_scan (WIDTH=8, DEPTH=3, RESET_VAL=A5).
module tb_dffr_pipe_scan;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;

  logic CK;
  logic RN;
  logic SE;
  logic SI;
  logic SO;

  int tests  = 0;
  int failed = 0;

  logic [23:0] scan_exp;

  dffr_pipe_scan_if #(.WIDTH(WIDTH)) bus ();

  dffr_pipe_scan #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'hA5)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .SE  (SE),
    .SI  (SI),
    .SO  (SO),
    .bus (bus.slave)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RN = 1'b0; SE = 1'b0; SI = 1'b0;
    bus.D = '0; bus.DV = 1'b0; bus.QR = 1'b0;

    // 1 reset
    step();
    chk("rst_q",  32'(bus.Q),  32'hA5);
    chk("rst_qn", 32'(bus.QN), 32'h5A);
    chk("rst_qv", 32'(bus.QV), 32'h0);
    chk("rst_dr", 32'(bus.DR), 32'h1);
    chk("rst_so", 32'(SO),     32'h1);
    RN = 1'b1;

    // 2 stream, latency DEPTH-1 edges after acceptance
    bus.QR = 1'b1; bus.DV = 1'b1; bus.D = 8'h01;
    step();
    bus.D = 8'h02;
    step();
    chk("str_qv_e2", 32'(bus.QV), 32'h0);
    bus.D = 8'h03;
    step();
    chk("str_q_e3",  32'(bus.Q),  32'h01);
    chk("str_qv_e3", 32'(bus.QV), 32'h1);
    chk("str_qn_e3", 32'(bus.QN), 32'hFE);
    bus.DV = 1'b0;
    step();
    chk("str_q_e4", 32'(bus.Q), 32'h02);
    step();
    chk("str_q_e5", 32'(bus.Q), 32'h03);
    step();
    chk("str_qv_e6", 32'(bus.QV), 32'h0);

    // 3 stall and drain
    RN = 1'b0; step(); RN = 1'b1;
    bus.QR = 1'b0; bus.DV = 1'b1; bus.D = 8'h11;
    step();
    bus.D = 8'h22;
    step();
    bus.D = 8'h33;
    chk("stl_dr_2", 32'(bus.DR), 32'h1);
    step();
    chk("stl_dr_full", 32'(bus.DR), 32'h0);
    chk("stl_q_full",  32'(bus.Q),  32'h11);
    chk("stl_qv_full", 32'(bus.QV), 32'h1);
    bus.D = 8'h44;
    step();
    step();
    chk("stl_q_hold",  32'(bus.Q),  32'h11);
    chk("stl_dr_hold", 32'(bus.DR), 32'h0);
    bus.QR = 1'b1;
    #1;
    chk("stl_dr_simul", 32'(bus.DR), 32'h1);
    step();
    chk("drn_q1", 32'(bus.Q), 32'h22);
    bus.DV = 1'b0;
    step();
    chk("drn_q2", 32'(bus.Q), 32'h33);
    step();
    chk("drn_q3",  32'(bus.Q),  32'h44);
    chk("drn_qv3", 32'(bus.QV), 32'h1);
    step();
    chk("drn_qv4", 32'(bus.QV), 32'h0);

    // 5 reset mid-stall
    bus.QR = 1'b0; bus.DV = 1'b1; bus.D = 8'h11;
    step();
    bus.D = 8'h22;
    step();
    bus.D = 8'h33;
    step();
    bus.DV = 1'b0;
    chk("mrs_full", 32'(bus.DR), 32'h0);
    RN = 1'b0;
    step();
    RN = 1'b1;
    chk("mrs_qv", 32'(bus.QV), 32'h0);
    chk("mrs_q",  32'(bus.Q),  32'hA5);
    chk("mrs_dr", 32'(bus.DR), 32'h1);
    bus.QR = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mrs_noold", 32'(bus.QV), 32'h0);
    end

    // 4 scan after reset; DV/QR asserted to show they are ignored
    RN = 1'b0; step(); RN = 1'b1;
    SE = 1'b1; SI = 1'b0; bus.DV = 1'b1; bus.D = 8'hFF; bus.QR = 1'b1;
    scan_exp = 24'hA5A5A5;
    #1;
    for (int k = 0; k < 24; k++) begin
      chk("scn_so", 32'(SO), 32'(scan_exp[23-k]));
      chk("scn_qv", 32'(bus.QV), 32'h0);
      chk("scn_dr", 32'(bus.DR), 32'h0);
      step();
    end
    chk("scn_q_end",  32'(bus.Q),  32'h00);
    chk("scn_qn_end", 32'(bus.QN), 32'hFF);
    SE = 1'b0; bus.DV = 1'b0;
    step(); step(); step();
    chk("scn_vfrozen", 32'(bus.QV), 32'h0);
    chk("scn_q_kept",  32'(bus.Q),  32'h00);

    // 6 reset beats scan
    SE = 1'b1; SI = 1'b1; RN = 1'b0;
    step();
    chk("pri_q",  32'(bus.Q),  32'hA5);
    chk("pri_qn", 32'(bus.QN), 32'h5A);
    chk("pri_so", 32'(SO),     32'h1);
    chk("pri_qv", 32'(bus.QV), 32'h0);
    chk("pri_dr", 32'(bus.DR), 32'h0);
    SE = 1'b0; RN = 1'b1;
    #1;
    chk("pri_dr_ns", 32'(bus.DR), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
